// File: rtl/aurora_tx_crc_sched_pkg.sv
// Shared types and constants for the Aurora TX CRC scheduler.
// The CRC helper is the one place the CRC-16 arithmetic lives: polynomial 0x1021,
// no final XOR, and data bit 0 is shifted in first to match the RX-side checker.
package aurora_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_PAD   = 3'd2,
        ST_CRC   = 3'd3,
        ST_FLUSH = 3'd4
    } state_e;

    localparam logic [15:0] CRC_POLY      = 16'h1021;
    localparam logic [3:0]  CRC_TAIL_KEEP = 4'hC;
    localparam logic [3:0]  PAD_KEEP      = 4'h0;
    localparam logic [3:0]  DATA_KEEP     = 4'hF;

    // Advance the CRC over one 32-bit word, bit 0 first
    function automatic logic [15:0] crc16_w32(input logic [15:0] crc_in,
                                              input logic [31:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int b = 0; b < 32; b++) begin
            fb = c[15] ^ data[b];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/aurora_tx_crc_sched_if.sv
// Bus bundle between the packet sources, the scheduler and the Aurora TX user port.
// modport master: the scheduler side (drives the TX stream and the source readies).
// modport slave : the environment side (sources and the Aurora core).
interface aurora_tx_crc_sched_if #(
    parameter int NUM_REQ = 2
);
    logic [32*NUM_REQ-1:0] s_axis_tdata;
    logic [NUM_REQ-1:0]    s_axis_tvalid;
    logic [NUM_REQ-1:0]    s_axis_tlast;
    logic [NUM_REQ-1:0]    s_axis_tready;
    logic [31:0]           m_axis_tdata;
    logic [3:0]            m_axis_tkeep;
    logic                  m_axis_tlast;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );
endinterface

// File: rtl/aurora_tx_crc_sched_crc16.sv
// Combinational next-CRC for one 32-bit word; also usable by the RX checker model.
module aurora_crc16_w32
    import aurora_tx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [31:0] data,
    output logic [15:0] crc_out
);
    assign crc_out = crc16_w32(crc_in, data);
endmodule

// File: rtl/aurora_tx_crc_sched.sv
// Round-robin scheduler sharing one Aurora TX user stream between NUM_REQ sources.
// Each packet is framed as data words, an optional pad word, then a CRC tail word.
// Build option: define AURORA_TX_PAD_EN to pad odd-length payloads to an even word
// count; without it odd payloads go straight to CRC and odd_len_err flags them.
module aurora_tx_crc_sched
    import aurora_tx_pkg::*;
#(
    parameter int          NUM_REQ  = 2,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic                  s_axis_aclk,
    input  logic                  areset,
    input  logic                  channel_up,
    aurora_tx_crc_sched_if.master bus,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  pkt_done,
    output logic                  odd_len_err
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   gidx_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [15:0]        crc_q;
    logic               word_cnt_q;
    logic [31:0]        m_tdata_q;
    logic [3:0]         m_tkeep_q;
    logic               m_tlast_q;
    logic               m_tvalid_q;

    logic               out_free_s;
    logic               pick_valid_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [NUM_REQ-1:0] s_tready_s;
    logic [31:0]        sel_data_s;
    logic               sel_last_s;
    logic               sel_acc_s;
    logic [31:0]        crc_data_s;
    logic [15:0]        crc_next_s;
    logic               crc_acc_s;

    // The output register can take a new word when empty or being drained this cycle
    assign out_free_s = !m_tvalid_q || bus.m_axis_tready;

    assign sel_data_s = bus.s_axis_tdata[32*gidx_q +: 32];
    assign sel_last_s = bus.s_axis_tlast[gidx_q];
    assign sel_acc_s  = bus.s_axis_tvalid[gidx_q] & s_tready_s[gidx_q];
    assign crc_acc_s  = (state_q == ST_CRC) & m_tvalid_q & m_tlast_q & bus.m_axis_tready;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             hit;
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        cand         = '0;
        hit          = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand         = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            hit          = !pick_valid_s && bus.s_axis_tvalid[cand];
            pick_idx_s   = hit ? cand : pick_idx_s;
            pick_valid_s = pick_valid_s | hit;
        end
    end

    // Only the granted source sees ready: throttled in DATA, free-running while draining
    always_comb begin
        s_tready_s = '0;
        case (state_q)
            ST_DATA:  s_tready_s = grant_q & {NUM_REQ{out_free_s}};
            ST_FLUSH: s_tready_s = grant_q;
            default:  s_tready_s = '0;
        endcase
    end

    // CRC input is the incoming word in DATA and all-zero for the pad word
    always_comb begin
        if (state_q == ST_DATA) begin
            crc_data_s = sel_data_s;
        end else begin
            crc_data_s = 32'h0000_0000;
        end
    end

    aurora_crc16_w32 u_crc (
        .crc_in  (crc_q),
        .data    (crc_data_s),
        .crc_out (crc_next_s)
    );

    // Packet FSM with arbitration, CRC accumulation and the registered output stage
    always_ff @(posedge s_axis_aclk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            crc_q      <= CRC_INIT;
            word_cnt_q <= 1'b0;
            m_tdata_q  <= 32'h0000_0000;
            m_tkeep_q  <= 4'h0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    m_tvalid_q <= 1'b0;
                    m_tlast_q  <= 1'b0;
                    if (channel_up && pick_valid_s) begin
                        grant_q    <= NUM_REQ'(1) << pick_idx_s;
                        gidx_q     <= pick_idx_s;
                        rr_ptr_q   <= (pick_idx_s == IDX_W'(NUM_REQ - 1)) ? '0
                                                                           : pick_idx_s + IDX_W'(1);
                        crc_q      <= CRC_INIT;
                        word_cnt_q <= 1'b0;
                        state_q    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!channel_up) begin
                        // Link lost: drop whatever is pending; a tlast taken now ends the packet
                        m_tvalid_q <= 1'b0;
                        if (sel_acc_s && sel_last_s) begin
                            grant_q <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_FLUSH;
                        end
                    end else if (sel_acc_s) begin
                        m_tdata_q  <= sel_data_s;
                        m_tkeep_q  <= DATA_KEEP;
                        m_tlast_q  <= 1'b0;
                        m_tvalid_q <= 1'b1;
                        crc_q      <= crc_next_s;
                        word_cnt_q <= ~word_cnt_q;
                        if (sel_last_s) begin
`ifdef AURORA_TX_PAD_EN
                            // Count was even before this word, so the payload is odd
                            state_q <= word_cnt_q ? ST_CRC : ST_PAD;
`else
                            state_q <= ST_CRC;
`endif
                        end
                    end else if (bus.m_axis_tready) begin
                        m_tvalid_q <= 1'b0;
                    end
                end
`ifdef AURORA_TX_PAD_EN
                ST_PAD: begin
                    if (!channel_up) begin
                        m_tvalid_q <= 1'b0;
                        grant_q    <= '0;
                        state_q    <= ST_IDLE;
                    end else if (out_free_s) begin
                        m_tdata_q  <= 32'h0000_0000;
                        m_tkeep_q  <= PAD_KEEP;
                        m_tlast_q  <= 1'b0;
                        m_tvalid_q <= 1'b1;
                        crc_q      <= crc_next_s;
                        word_cnt_q <= ~word_cnt_q;
                        state_q    <= ST_CRC;
                    end
                end
`endif
                ST_CRC: begin
                    if (!channel_up) begin
                        m_tvalid_q <= 1'b0;
                        m_tlast_q  <= 1'b0;
                        grant_q    <= '0;
                        state_q    <= ST_IDLE;
                    end else if (crc_acc_s) begin
                        m_tvalid_q <= 1'b0;
                        m_tlast_q  <= 1'b0;
                        grant_q    <= '0;
                        state_q    <= ST_IDLE;
                    end else if (!m_tlast_q && out_free_s) begin
                        // m_tlast_q doubles as "CRC word already loaded"
                        m_tdata_q  <= {crc_q, 16'h0000};
                        m_tkeep_q  <= CRC_TAIL_KEEP;
                        m_tlast_q  <= 1'b1;
                        m_tvalid_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    m_tvalid_q <= 1'b0;
                    m_tlast_q  <= 1'b0;
                    if (sel_acc_s && sel_last_s) begin
                        grant_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    m_tvalid_q <= 1'b0;
                    grant_q    <= '0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_axis_tready = s_tready_s;
    assign bus.m_axis_tdata  = m_tdata_q;
    assign bus.m_axis_tkeep  = m_tkeep_q;
    assign bus.m_axis_tlast  = m_tlast_q;
    assign bus.m_axis_tvalid = m_tvalid_q;
    assign grant             = grant_q;
    assign pkt_done          = crc_acc_s & channel_up;
`ifdef AURORA_TX_PAD_EN
    assign odd_len_err       = 1'b0;
`else
    assign odd_len_err       = crc_acc_s & channel_up & word_cnt_q;
`endif

endmodule

// File: tb/tb_aurora_tx_crc_sched.sv
// Scoreboard bench for aurora_tx_crc_sched: a packet-level model builds the expected
// output beats (data, optional pad, CRC tail) and the arbitration order; a monitor
// pops and compares every accepted output beat.
`timescale 1ns/1ps
module tb_aurora_tx_crc_sched;
    localparam int          NR   = 2;
    localparam logic [15:0] INIT = 16'hFFFF;
`ifdef AURORA_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          req;
        logic        odd;
    } beat_t;

    logic          clk;
    logic          rst;
    logic          ch_up;
    logic [NR-1:0] grant;
    logic          pkt_done;
    logic          odd_len_err;

    aurora_tx_crc_sched_if #(.NUM_REQ(NR)) bus ();

    aurora_tx_crc_sched #(.NUM_REQ(NR), .CRC_INIT(INIT)) dut (
        .s_axis_aclk (clk),
        .areset      (rst),
        .channel_up  (ch_up),
        .bus         (bus),
        .grant       (grant),
        .pkt_done    (pkt_done),
        .odd_len_err (odd_len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t         expq[$];
    logic [32:0]   srcq[NR][$];
    int            pend_len[NR][$];
    logic [31:0]   pend_w[NR][$];
    logic [31:0]   stage[$];
    logic [NR-1:0] acc_s;
    int            pop_cnt[NR];
    int            checks;
    int            errors;
    int            model_rr;
    int            tready_mode;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit src_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NR; i++) if (srcq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input int r, input logic o);
        beat_t b;
        b.data = d; b.keep = k; b.last = l; b.req = r; b.odd = o;
        expq.push_back(b);
    endtask

    // Queue the staged words as one packet for requester r
    task automatic add_pkt(input int r);
        int len;
        len = stage.size();
        pend_len[r].push_back(len);
        for (int j = 0; j < len; j++) begin
            pend_w[r].push_back(stage[j]);
            srcq[r].push_back({(j == len - 1), stage[j]});
        end
        stage.delete();
    endtask

    task automatic add_rand(input int r, input int len);
        for (int j = 0; j < len; j++) stage.push_back($urandom());
        add_pkt(r);
    endtask

    // Packet-level model: round-robin order, framing and CRC over the whole bit stream
    task automatic schedule();
        int          found;
        int          len;
        int          r;
        logic [31:0] w;
        logic [15:0] c;
        bit          fb;
        bit          stream[$];
        forever begin
            found = -1;
            for (int k = 0; k < NR; k++) begin
                r = (model_rr + k) % NR;
                if (found < 0 && pend_len[r].size() > 0) found = r;
            end
            if (found < 0) break;
            len = pend_len[found].pop_front();
            stream.delete();
            for (int j = 0; j < len; j++) begin
                w = pend_w[found].pop_front();
                push_beat(w, 4'hF, 1'b0, found, 1'b0);
                for (int b = 0; b < 32; b++) stream.push_back(w[b]);
            end
            if (PAD_EN && (len % 2 == 1)) begin
                push_beat(32'h0, 4'h0, 1'b0, found, 1'b0);
                for (int b = 0; b < 32; b++) stream.push_back(1'b0);
            end
            c = INIT;
            foreach (stream[n]) begin
                fb = c[15] ^ stream[n];
                c  = {c[14:0], 1'b0} ^ ({16{fb}} & 16'h1021);
            end
            push_beat({c, 16'h0000}, 4'hC, 1'b1, found, (len % 2 == 1));
            model_rr = (found + 1) % NR;
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk);
            done = (expq.size() == 0) && src_empty();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout pending_beats=%0d required=0", expq.size());
            expq.delete();
            for (int i = 0; i < NR; i++) srcq[i].delete();
        end
        repeat (3) @(posedge clk);
    endtask

    // Source and sink driver: inputs change 1 ns after the rising edge
    initial begin
        logic [32:0] h;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < NR; i++) pop_cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (!rst && acc_s[i] && srcq[i].size() > 0) begin
                    void'(srcq[i].pop_front());
                    pop_cnt[i]++;
                end
                if (srcq[i].size() > 0) begin
                    h = srcq[i][0];
                    bus.s_axis_tvalid[i]          = 1'b1;
                    bus.s_axis_tdata[32*i +: 32]  = h[31:0];
                    bus.s_axis_tlast[i]           = h[32];
                end else begin
                    bus.s_axis_tvalid[i] = 1'b0;
                    bus.s_axis_tlast[i]  = 1'b0;
                end
            end
            bus.m_axis_tready = (tready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: samples on the falling edge and compares accepted beats with the scoreboard
    initial begin
        beat_t       e;
        bit          hold;
        logic [36:0] held;
        hold = 1'b0;
        held = '0;
        acc_s = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc_s = '0;
                hold  = 1'b0;
            end else begin
                for (int i = 0; i < NR; i++)
                    acc_s[i] = bus.s_axis_tvalid[i] & bus.s_axis_tready[i];
                if (hold) begin
                    chk("hold_valid", 64'(bus.m_axis_tvalid), 64'd1);
                    chk("hold_word", 64'({bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast}),
                        64'(held));
                end
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%h required=none", bus.m_axis_tdata);
                    end else begin
                        e = expq.pop_front();
                        chk("tdata", 64'(bus.m_axis_tdata), 64'(e.data));
                        chk("tkeep", 64'(bus.m_axis_tkeep), 64'(e.keep));
                        chk("tlast", 64'(bus.m_axis_tlast), 64'(e.last));
                        chk("grant", 64'(grant), 64'd1 << e.req);
                        chk("pkt_done", 64'(pkt_done), 64'(e.last));
                        chk("odd_len_err", 64'(odd_len_err), 64'(e.last && e.odd && !PAD_EN));
                    end
                end else begin
                    chk("pkt_done_idle", 64'(pkt_done), 64'd0);
                    chk("odd_len_err_idle", 64'(odd_len_err), 64'd0);
                end
                hold = bus.m_axis_tvalid && !bus.m_axis_tready;
                held = {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast};
            end
        end
    end

    // Test sequence
    initial begin
        int base;
        bit got;
        logic [31:0] bp_words[6];
        checks = 0; errors = 0; model_rr = 0; tready_mode = 0;
        rst = 1'b1; ch_up = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(bus.m_axis_tdata), 64'd0);
        chk("rst_tkeep", 64'(bus.m_axis_tkeep), 64'd0);
        chk("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("rst_pkt_done", 64'(pkt_done), 64'd0);
        chk("rst_odd", 64'(odd_len_err), 64'd0);
        rst = 1'b0;

        // Two-word packet on requester 0
        stage.push_back(32'h0123_4567);
        stage.push_back(32'h89AB_CDEF);
        add_pkt(0);
        schedule();
        wait_idle(200);

        // Odd-length packet on requester 1
        add_rand(1, 3);
        schedule();
        wait_idle(200);

        // Both requesters busy: grants must alternate
        add_rand(0, 4); add_rand(1, 4); add_rand(0, 4); add_rand(1, 4);
        schedule();
        wait_idle(400);

        // Same 6-word packet without and with random backpressure
        for (int j = 0; j < 6; j++) bp_words[j] = $urandom();
        for (int j = 0; j < 6; j++) stage.push_back(bp_words[j]);
        add_pkt(0);
        schedule();
        wait_idle(200);
        tready_mode = 1;
        for (int j = 0; j < 6; j++) stage.push_back(bp_words[j]);
        add_pkt(0);
        schedule();
        wait_idle(400);
        tready_mode = 0;

        // Link drop on the third word of an 8-word packet
        for (int j = 0; j < 8; j++) stage.push_back($urandom());
        push_beat(stage[0], 4'hF, 1'b0, 0, 1'b0);
        push_beat(stage[1], 4'hF, 1'b0, 0, 1'b0);
        for (int j = 0; j < 8; j++) srcq[0].push_back({(j == 7), stage[j]});
        stage.delete();
        model_rr = 1;
        base = pop_cnt[0];
        got  = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk);
            #2;
            if (pop_cnt[0] >= base + 2) got = 1'b1;
        end
        chk("flush_reach_word3", 64'(got), 64'd1);
        ch_up = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("flush_tvalid_drop", 64'(bus.m_axis_tvalid), 64'd0);
        for (int c = 0; c < 100 && !src_empty(); c++) @(posedge clk);
        repeat (2) @(negedge clk);
        chk("flush_drained", 64'(srcq[0].size()), 64'd0);
        chk("flush_grant_clear", 64'(grant), 64'd0);
        wait_idle(50);
        ch_up = 1'b1;
        add_rand(1, 2);
        schedule();
        wait_idle(200);

        // Asynchronous reset in the middle of a packet
        add_rand(1, 6);
        schedule();
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("arst_tdata", 64'(bus.m_axis_tdata), 64'd0);
        chk("arst_tkeep", 64'(bus.m_axis_tkeep), 64'd0);
        chk("arst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("arst_pkt_done", 64'(pkt_done), 64'd0);
        expq.delete();
        for (int i = 0; i < NR; i++) srcq[i].delete();
        acc_s = '0;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        model_rr = 0;
        add_rand(1, 2);
        add_rand(0, 2);
        schedule();
        wait_idle(200);

        // Randomized traffic with random backpressure
        tready_mode = 1;
        for (int p = 0; p < 12; p++) add_rand($urandom_range(0, NR - 1), $urandom_range(1, 8));
        schedule();
        wait_idle(3000);
        tready_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aurora_tx_crc_sched.md
# aurora_tx_crc_sched

Round-robin scheduler that shares one Aurora user TX AXI-Stream channel between `NUM_REQ` packet sources. For each packet it frames the data, pads odd-length payloads to an even word count and appends a CRC tail word, so that the framing matches what the RX-side CRC checker expects. It sits between the local packet sources and the Aurora core TX user interface.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, range 2–8.
- `CRC_INIT`, default 16'hFFFF: CRC seed loaded at the start of each packet.

Ports (one clock; reset is asynchronous and active-high):
- `s_axis_aclk`  in  1  clock.
- `areset`  in  1  asynchronous, active-high reset.
- `channel_up`  in  1  Aurora link status.
- `s_axis_tdata`  in  32*NUM_REQ  packed requester data; requester i uses bits [32i+31:32i].
- `s_axis_tvalid`  in  NUM_REQ  per-requester valid.
- `s_axis_tlast`  in  NUM_REQ  per-requester end of packet.
- `s_axis_tready`  out  NUM_REQ  per-requester ready.
- `m_axis_tdata`  out  32  to Aurora TX.
- `m_axis_tkeep`  out  4  byte enables.
- `m_axis_tlast`  out  1  set on the CRC word only.
- `m_axis_tvalid`  out  1.
- `m_axis_tready`  in  1.
- `grant`  out  NUM_REQ  one-hot; held for the whole packet.
- `pkt_done`  out  1  one-cycle pulse when the CRC word is accepted.
- `odd_len_err`  out  1  one-cycle pulse (only when `AURORA_TX_PAD_EN` is not defined).

## Operation
- **Input format:** all input words are treated as full (tkeep 4'hF). Payload length is 1 or more words.
- **State machine:** IDLE → DATA → [PAD] → CRC → IDLE. Any state goes to FLUSH when `channel_up` falls mid-packet.
- **IDLE:**
  - Requires `channel_up`.
  - Picks the lowest index at or after `rr_ptr` with tvalid set, wrapping modulo `NUM_REQ`.
  - Sets `grant`, loads `CRC_INIT`, clears `word_cnt`, then goes to DATA.
  - `rr_ptr` becomes granted index + 1, wrapping to 0.
- **DATA:**
  - `s_axis_tready[g] = (!m_axis_tvalid || m_axis_tready)`; all other tready bits are 0.
  - Each accepted word is registered to the output with tkeep 4'hF and tlast 0.
  - The CRC is updated with the word, and `word_cnt` toggles its LSB.
  - On the accepted tlast word, the next state is PAD if the count is odd (with `AURORA_TX_PAD_EN`), otherwise CRC.
- **PAD:** emits one word: tdata 32'h0, tkeep 4'h0, tlast 0. The pad word is included in the CRC.
- **CRC:**
  - Emits tdata = {crc[15:0], 16'h0}, tkeep 4'hC, tlast 1.
  - When it is accepted, `pkt_done` pulses, `grant` clears, and the state returns to IDLE.
- **FLUSH:**
  - Entered from DATA, PAD or CRC when `channel_up` = 0.
  - `m_axis_tvalid` drops immediately and any pending output word is discarded.
  - The granted requester is drained with tready = 1 until its tlast is accepted; then IDLE.
  - If the abort occurs in PAD or CRC, the requester's tlast has already been taken, so the next state is IDLE directly.
- **CRC arithmetic:**
  - CRC-16, polynomial 0x1021, 32 bits per cycle.
  - Word bit 0 (tdata[0:31] ordering) is processed first, which is bit-compatible with the RX checker.
  - No final XOR.

## Timing
- **Reset values:** all outputs 0; `rr_ptr` 0; state IDLE; crc = `CRC_INIT`.
- **Grant latency:** 1 cycle from tvalid in IDLE to `grant`; the first data tready is in the following cycle.
- **Data latency:** 1 cycle from input acceptance to `m_axis_tvalid`.
- **Throughput:** one word per cycle at full tready.
- **Per-packet overhead:** one IDLE cycle, 0 or 1 pad word, and 1 CRC word.
- **Output stability:** `m_axis_*` are registered and stay stable while tvalid is high and tready is low (AXI rule).
- **Simultaneous events:** a tlast word accepted in the same cycle that `channel_up` falls is treated as accepted, and the state goes to IDLE with no CRC word.
- **Requests during a packet:** new requests arriving in DATA wait; there is no preemption.

## Configuration
- **`AURORA_TX_PAD_EN` defined:** odd-length payloads get a PAD word, and `odd_len_err` is tied to 0.
- **`AURORA_TX_PAD_EN` not defined:**
  - The PAD state is not built, and odd payloads go straight to CRC.
  - `odd_len_err` pulses in the same cycle the CRC word is accepted.

## Structure
- **Shared package `aurora_tx_pkg`:**
  - State enum.
  - `CRC_POLY` = 16'h1021.
  - `CRC_TAIL_KEEP` = 4'hC.
  - `PAD_KEEP` = 4'h0.
- **Sub-module `aurora_crc16_w32`:** combinational next-CRC function (inputs crc_in[15:0] and data[31:0]), shared with the RX checker model.
- **Top level:** the arbiter, FSM and output register stay in `aurora_tx_crc_sched`.

## Test plan
- Req0 sends a 2-word packet (0x01234567, 0x89ABCDEF) with m_tready held at 1 → 2 data words, then a CRC word with tkeep 4'hC and tlast; CRC matches the software model and `pkt_done` pulses once.
- Req1 sends 3 words with `AURORA_TX_PAD_EN` defined → 3 data words, a pad word (0, tkeep 0), then the CRC word. Without the macro: 3 data words, then the CRC word, with `odd_len_err` = 1 on the CRC beat.
- Req0 and req1 both valid continuously, 4-word packets → grants alternate 0, 1, 0, 1; no interleaving of words within a packet.
- m_tready toggles with a random 50% pattern on a 6-word packet → output words and data unchanged under backpressure, and the CRC is identical to the case with no backpressure.
- `channel_up` is dropped on the 3rd word of an 8-word packet → m_tvalid goes to 0 the next cycle, no tlast is emitted, the requester is drained through its tlast, and the next packet starts from IDLE with a fresh CRC.
- `areset` is asserted mid-packet → all outputs read 0 asynchronously; after release the grant starts at requester 0.
